// File: rtl/shake_pkg.sv
// Shared constants and helpers for the SHAKE pad/absorb feeder.
package shake_pkg;

    localparam int unsigned RATE_BYTES = 136;

    localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
    localparam logic [7:0] PAD_FINAL    = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } pad_state_e;

    // Lane 0 is the most significant byte of the block.
    function automatic int unsigned lane_msb(input int unsigned rate_width, input int unsigned i);
        return rate_width - 1 - 8 * i;
    endfunction

endpackage

// File: rtl/shake_pad_absorb_feeder.sv
// Packs a byte stream into rate-sized blocks, applies SHAKE suffix and pad10*1,
// and hands finished blocks to the sponge core over valid/ready.
module shake_pad_absorb_feeder
    import shake_pkg::*;
#(
    parameter int unsigned RATE_WIDTH    = RATE_BYTES * 8,
    parameter logic [7:0]  DOMAIN_SUFFIX = SHAKE_SUFFIX,
    parameter logic [7:0]  FINAL_PAD     = PAD_FINAL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_empty,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [RATE_WIDTH-1:0] blk_data,
    output logic                  blk_last,
    output logic [1:0]            debug_pad_fsm
);

    localparam int unsigned RB    = RATE_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(RB + 1);

    pad_state_e            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_inc;
    logic [IDX_W-1:0]      next_free;
    logic                  pend_pad;
    logic                  lane_wr;
    logic [7:0]            lane_byte;
    logic [RATE_WIDTH-1:0] data_next;

    assign in_ready      = (state == FILL) && !reset;
    assign blk_valid     = (state == EMIT);
    assign debug_pad_fsm = state;

    assign idx_inc   = idx + IDX_W'(1);
    assign next_free = in_empty ? idx : idx_inc;
    assign lane_wr   = ((state == FILL) && in_valid && !in_empty) || (state == PAD);
    assign lane_byte = (state == PAD) ? DOMAIN_SUFFIX : in_data;

    // Single lane writer shared by message bytes and the domain suffix.
    always_comb begin
        data_next = blk_data;
        for (int unsigned i = 0; i < RB; i++) begin
            if (lane_wr && (idx == IDX_W'(i))) begin
                data_next[lane_msb(RATE_WIDTH, i) -: 8] = lane_byte;
            end
        end
        if (state == PAD) begin
            data_next[7:0] = data_next[7:0] | FINAL_PAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            idx      <= '0;
            pend_pad <= 1'b0;
            blk_data <= '0;
            blk_last <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        blk_data <= data_next;
                        if (in_last) begin
                            if (next_free == IDX_W'(RB)) begin
                                // Exactly full: padding goes into a separate block.
                                state    <= EMIT;
                                blk_last <= 1'b0;
                                pend_pad <= 1'b1;
                                idx      <= '0;
                            end else begin
                                state <= PAD;
                                idx   <= next_free;
                            end
                        end else if (!in_empty) begin
                            idx <= idx_inc;
                            if (idx == IDX_W'(RB - 1)) begin
                                state    <= EMIT;
                                blk_last <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    blk_data <= data_next;
                    blk_last <= 1'b1;
                    state    <= EMIT;
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_data <= '0;
                        idx      <= '0;
                        if (pend_pad) begin
                            pend_pad <= 1'b0;
                            state    <= PAD;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_pad_absorb_feeder.sv
// Directed bench for the SHAKE pad/absorb feeder with hand-built expected blocks.
module tb_shake_pad_absorb_feeder;

    localparam int RW = 1088;
    localparam int RB = 136;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_empty;
    logic          blk_valid;
    logic          blk_ready;
    logic [RW-1:0] blk_data;
    logic          blk_last;
    logic [1:0]    debug_pad_fsm;

    int n_cmp = 0;
    int n_bad = 0;

    shake_pad_absorb_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_empty      (in_empty),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_data      (blk_data),
        .blk_last      (blk_last),
        .debug_pad_fsm (debug_pad_fsm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] set_lane(input logic [RW-1:0] v, input int i,
                                                input logic [7:0] b);
        logic [RW-1:0] r;
        r = v;
        r[RW-1-8*i -: 8] = b;
        return r;
    endfunction

    // Suffix at lane k, final pad bit ORed into the last lane.
    function automatic logic [RW-1:0] pad_at(input logic [RW-1:0] v, input int k);
        logic [RW-1:0] r;
        r = set_lane(v, k, 8'h1F);
        r[7:0] = r[7:0] | 8'h80;
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input logic last, input logic empty);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_timeout: observed in_ready=0 expected 1");
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [RW-1:0] exp_d, input logic exp_last);
        int t;
        t = 0;
        while (!blk_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 32'(blk_valid), 32'd1);
        chkb({tag, "_data"}, blk_data, exp_d);
        chk({tag, "_last"}, 32'(blk_last), 32'(exp_last));
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    logic [RW-1:0] exp_blk;
    logic [RW-1:0] abc_blk;
    logic [7:0]    b;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_empty  = 1'b0;
        blk_ready = 1'b0;

        abc_blk = '0;
        abc_blk = set_lane(abc_blk, 0, 8'h61);
        abc_blk = set_lane(abc_blk, 1, 8'h62);
        abc_blk = set_lane(abc_blk, 2, 8'h63);
        abc_blk = pad_at(abc_blk, 3);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_blk_valid", 32'(blk_valid), 32'd0);
        chk("rst_blk_last", 32'(blk_last), 32'd0);
        chkb("rst_blk_data", blk_data, '0);
        chk("rst_fsm", 32'(debug_pad_fsm), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // blk_ready outside EMIT is ignored
        @(negedge clk);
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stray_ready_fsm", 32'(debug_pad_fsm), 32'd0);
        chk("stray_ready_in_ready", 32'(in_ready), 32'd1);
        blk_ready = 1'b0;

        // Empty message: valid two cycles after the accepting edge
        send(8'h00, 1'b1, 1'b1);
        chk("empty_lat1_valid", 32'(blk_valid), 32'd0);
        chk("empty_lat1_fsm", 32'(debug_pad_fsm), 32'd1);
        @(posedge clk);
        #1;
        chk("empty_lat2_valid", 32'(blk_valid), 32'd1);
        recv("empty", pad_at('0, 0), 1'b1);

        // "abc" with an ignored empty-without-last beat in the middle
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'hEE, 1'b0, 1'b1);
        send(8'h63, 1'b1, 1'b0);
        recv("abc", abc_blk, 1'b1);

        // 135 bytes: suffix lands in the last lane together with the final pad bit
        exp_blk = '0;
        for (int i = 0; i < 135; i++) begin
            send(8'hA5, (i == 134), 1'b0);
            exp_blk = set_lane(exp_blk, i, 8'hA5);
        end
        exp_blk = set_lane(exp_blk, 135, 8'h9F);
        recv("a5x135", exp_blk, 1'b1);

        // 136 zero bytes: full block then a pad-only block
        for (int i = 0; i < 136; i++) send(8'h00, (i == 135), 1'b0);
        chk("z136_lat_valid", 32'(blk_valid), 32'd1);
        recv("z136_blk1", '0, 1'b0);
        recv("z136_blk2", pad_at('0, 0), 1'b1);

        // 300 bytes with downstream stalled for 10 cycles on the first block
        exp_blk = '0;
        for (int i = 0; i < 136; i++) begin
            b = 8'(i * 7 + 3);
            send(b, 1'b0, 1'b0);
            exp_blk = set_lane(exp_blk, i, b);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chkb("stall_data", blk_data, exp_blk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_fsm", 32'(debug_pad_fsm), 32'd2);
        end
        recv("m300_blk1", exp_blk, 1'b0);
        exp_blk = '0;
        for (int i = 136; i < 272; i++) begin
            b = 8'(i * 7 + 3);
            send(b, 1'b0, 1'b0);
            exp_blk = set_lane(exp_blk, i - 136, b);
        end
        recv("m300_blk2", exp_blk, 1'b0);
        exp_blk = '0;
        for (int i = 272; i < 300; i++) begin
            b = 8'(i * 7 + 3);
            send(b, (i == 299), 1'b0);
            exp_blk = set_lane(exp_blk, i - 272, b);
        end
        exp_blk = pad_at(exp_blk, 28);
        recv("m300_blk3", exp_blk, 1'b1);

        // Reset mid-message, then a clean "abc"
        for (int i = 0; i < 50; i++) send(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midmsg_rst_in_ready", 32'(in_ready), 32'd0);
        chk("midmsg_rst_valid", 32'(blk_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midmsg_rel_in_ready", 32'(in_ready), 32'd1);
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'h63, 1'b1, 1'b0);
        recv("abc_after_rst", abc_blk, 1'b1);

        // Reset while a block is waiting in EMIT drops it asynchronously
        for (int i = 0; i < 136; i++) send(8'hC3, 1'b0, 1'b0);
        chk("emit_pre_rst_valid", 32'(blk_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("emit_rst_valid", 32'(blk_valid), 32'd0);
        chkb("emit_rst_data", blk_data, '0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'h63, 1'b1, 1'b0);
        recv("abc_after_emit_rst", abc_blk, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shake_pad_absorb_feeder.md
Name: shake_pad_absorb_feeder

Overview:
- Upstream neighbour of the multi-block Keccak sponge core.
- Accepts an arbitrary-length message as a byte stream and packs it into RATE_WIDTH-bit blocks.
- Applies SHAKE domain separation and pad10*1, then hands each finished block downstream over a valid/ready handshake, with a last-block flag.
- Lets the sponge absorb messages whose length is not known at elaboration time.

Parameters:
- RATE_WIDTH, 1088: block width in bits; must be a multiple of 8.
- DOMAIN_SUFFIX, 8'h1F: byte placed immediately after the final message byte (SHAKE suffix plus first pad bit).
- FINAL_PAD, 8'h80: byte ORed into the last byte lane of the final block.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  message byte valid
- in_ready  out  1  feeder can accept a byte
- in_data  in  8  message byte
- in_last  in  1  this beat ends the message
- in_empty  in  1  qualifies in_last: the message ends with no data byte on this beat (in_data ignored); covers zero-length messages
- blk_valid  out  1  blk_data holds a complete block
- blk_ready  in  1  downstream accepts the block
- blk_data  out  RATE_WIDTH  padded block
- blk_last  out  1  this block is the final padded block of the message
- debug_pad_fsm  out  2  current FSM state

Behaviour:
- Definitions:
  - RB = RATE_WIDTH/8 = 136 byte lanes.
  - Byte lane i occupies blk_data[RATE_WIDTH-1-8*i -: 8], so lane 0 is the most significant byte.
  - The downstream core treats the most significant bits of a block as first-absorbed.
- Reset (async, active-high):
  - state=FILL, lane index idx=0, pend_pad=0.
  - blk_data=0, blk_valid=0, blk_last=0.
  - in_ready=0 while reset is asserted.
- States: FILL=0, PAD=1, EMIT=2.
  - in_ready = (state==FILL) && !reset.
  - blk_valid = (state==EMIT).
- FILL:
  - A byte is accepted when in_valid && in_ready.
  - A non-empty accept writes in_data to lane idx, then idx++.
  - Non-last accept with idx==RB-1: go to EMIT, blk_last=0.
  - Last accept, with k = next free lane after the write (k = idx if in_empty):
    - k<RB: go to PAD with idx=k.
    - k==RB (block filled exactly): go to EMIT with blk_last=0 and pend_pad=1.
- PAD (exactly one cycle):
  - Lanes above idx are already zero.
  - Lane idx gets DOMAIN_SUFFIX; lane RB-1 is ORed with FINAL_PAD.
  - When idx==RB-1, lane RB-1 therefore becomes 8'h9F.
  - Go to EMIT with blk_last=1.
- EMIT:
  - blk_data and blk_last are held stable until blk_valid && blk_ready.
  - On that handshake, blk_data is cleared to 0 and idx=0.
  - If pend_pad: clear pend_pad, go to PAD with idx=0 (pad-only block).
  - Otherwise: go to FILL.
- Latency, counted from the accepting edge of the final byte:
  - Full non-final block: blk_valid asserts the next cycle.
  - Final padded block: blk_valid asserts 2 cycles later.
- Throughput: no bytes are accepted during PAD or EMIT; a single-block buffer is sufficient by design.
- blk_ready arriving while not in EMIT is ignored.
- in_empty without in_last is ignored: no write, no state change, byte consumed.
- Back-to-back messages: after the final block handshake the feeder returns to FILL with a clean buffer. No state carries over between messages.
- Reset mid-message or mid-EMIT:
  - Drops the partial block immediately.
  - blk_valid deasserts asynchronously.
  - No partial block is ever emitted after reset.
- Width rules:
  - idx width is $clog2(RB+1).
  - All lane writes are full bytes; no bit-level padding is supported (byte-aligned messages only).

Decomposition:
- Package shake_pkg:
  - RATE_BYTES localparam.
  - State encoding constants FILL/PAD/EMIT.
  - SHAKE_SUFFIX=8'h1F and PAD_FINAL=8'h80.
  - A lane-offset function lane_msb(i).
- No sub-module is warranted.
- The byte-lane write logic is a single generate/loop inside the module.
- The downstream sponge core consumes blk_data/blk_last directly.

Test Plan:
- Empty message (in_last=1, in_empty=1) → one block: lane0=8'h1F, lanes1..134=0, lane135=8'h80, blk_last=1; blk_valid 2 cycles after accept.
- "abc" (61,62,63, last on 63) → one block: lanes0..2=61 62 63, lane3=1F, lane135=80, blk_last=1.
- 135 bytes of 8'hA5 with last on byte 135 → one block: lanes0..134=A5, lane135=9F, blk_last=1.
- 136 bytes of 8'h00 with last on byte 136 → block1 all zero with blk_last=0; then block2 lane0=1F, lane135=80, blk_last=1.
- blk_ready held low 10 cycles during EMIT of a 300-byte message → blk_data stable, in_ready=0 throughout; 3 blocks total, only the third has blk_last=1 (lane28=1F, lane135=80).
- reset pulsed after 50 bytes → blk_valid=0, in_ready low then high; a following "abc" message produces the exact block from the "abc" case with no residue.
